// File: rtl/ps2_receiver.sv
// Host-side PS/2 device-to-host frame receiver with clock filter.
// Optional frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick,
  output logic       rx_idle
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;

  logic                  data_m;
  logic                  data_s;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  filt_next;
  logic                  fall_edge;
  logic [9:0]            frame;
  logic [3:0]            bit_cnt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign timeout_tick = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_m   <= 1'b1;
      data_s   <= 1'b1;
      filt_sr  <= '1;
      filt_clk <= 1'b1;
    end else begin
      data_m   <= ps2_data;
      data_s   <= data_m;
      filt_sr  <= {filt_sr[FILTER_LEN-2:0], ps2_clk};
      filt_clk <= filt_next;
    end
  end

  always_comb begin
    filt_next = filt_clk;
    if (&filt_sr)
      filt_next = 1'b1;
    else if (~|filt_sr)
      filt_next = 1'b0;
  end

  assign fall_edge = filt_clk & ~filt_next;
  assign rx_idle   = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      frame        <= '0;
      bit_cnt      <= '0;
      dout         <= 8'h00;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_tick <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      timeout_tick <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall_edge && rx_en && !data_s) begin
            bit_cnt <= 4'd9;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            state   <= RECV;
          end
        end
        RECV: begin
          // disable has priority over a coincident clock edge
          if (!rx_en) begin
            state <= IDLE;
          end else if (fall_edge) begin
            frame <= {data_s, frame[9:1]};
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt <= '0;
`endif
            if (bit_cnt == 4'd0) begin
              state        <= DONE;
              rx_done_tick <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
`ifdef PS2_RX_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            timeout_tick <= 1'b1;
            state        <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          dout       <= frame[7:0];
          parity_err <= ~(^frame[8:0]);
          frame_err  <= ~frame[9];
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
